// File: rtl/dbginit_pkg.sv
// Shared definitions for the dbginit stimulus sequencer: state encoding and
// default widths. Optional quiesce timeout is enabled with DBGINIT_GEN_QTIMEOUT_EN.
package dbginit_pkg;

    localparam int ASSERT_W_DEF  = 11;
    localparam int IDLE_W_DEF    = 16;
    localparam int NPULSE_W_DEF  = 8;
    localparam int TO_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_WAIT_Q    = 3'd2,
        ST_ASSERT    = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/dbginit_dcnt.sv
// Loadable down-counter that parks at zero and flags it; used for the idle gap,
// the assert length and the quiesce timeout.
module dbginit_dcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dbginit_gen.sv
// Active-low dbginit pulse-train sequencer feeding the dbginit monitors.
// Define DBGINIT_GEN_QTIMEOUT_EN to abort a request when quiesce stays high too long.
module dbginit_gen
    import dbginit_pkg::*;
#(
    parameter int ASSERT_W  = ASSERT_W_DEF,
    parameter int IDLE_W    = IDLE_W_DEF,
    parameter int NPULSE_W  = NPULSE_W_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IDLE_W-1:0]   idle_cycles,
    input  logic [ASSERT_W-1:0] assert_cycles,
    input  logic [NPULSE_W-1:0] num_pulses,
    input  logic                quiesce,
    output logic                dbginit,
    output logic [ASSERT_W-1:0] cnt_val,
    output logic [NPULSE_W-1:0] pulse_cnt,
    output logic                busy,
    output logic                done,
    output logic                err_timeout
);

    // A programmed length of 0 behaves as 1; counters load length-1.
    function automatic logic [IDLE_W-1:0] sat_m1_idle(input logic [IDLE_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [ASSERT_W-1:0] sat_m1_assert(input logic [ASSERT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    state_t              state, state_nxt;
    logic [IDLE_W-1:0]   idle_m1, idle_load_val;
    logic [NPULSE_W-1:0] num_lat, pulse_inc;
    logic                take_start;
    logic                idle_load, idle_zero;
    logic                asrt_load, asrt_zero;
    logic                to_hit;

    assign take_start    = (state == ST_IDLE) && start;
    assign pulse_inc     = pulse_cnt + 1'b1;
    assign idle_load_val = take_start ? sat_m1_idle(idle_cycles) : idle_m1;

    dbginit_dcnt #(.W(IDLE_W)) u_idle (
        .clk      (clk),
        .rst      (rst),
        .load     (idle_load),
        .load_val (idle_load_val),
        .dec      (state == ST_WAIT_IDLE),
        .zero     (idle_zero)
    );

    // cnt_val already holds the saturated length-1, so it doubles as the reload value.
    dbginit_dcnt #(.W(ASSERT_W)) u_asrt (
        .clk      (clk),
        .rst      (rst),
        .load     (asrt_load),
        .load_val (cnt_val),
        .dec      (state == ST_ASSERT),
        .zero     (asrt_zero)
    );

`ifdef DBGINIT_GEN_QTIMEOUT_EN
    localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic to_run, to_zero;

    assign to_run = (state == ST_WAIT_Q) && quiesce;

    dbginit_dcnt #(.W(TO_W)) u_to (
        .clk      (clk),
        .rst      (rst),
        .load     (!to_run),
        .load_val (TO_W'(TO_CYCLES - 1)),
        .dec      (to_run),
        .zero     (to_zero)
    );

    assign to_hit = to_run && to_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= to_hit;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idle_load = 1'b0;
        asrt_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (num_pulses == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_IDLE;
                        idle_load = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (idle_zero) state_nxt = ST_WAIT_Q;
            end
            ST_WAIT_Q: begin
                if (!quiesce) begin
                    state_nxt = ST_ASSERT;
                    asrt_load = 1'b1;
                end else if (to_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (asrt_zero) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (pulse_inc == num_lat) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT_IDLE;
                    idle_load = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dbginit   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
            cnt_val   <= '0;
        end else begin
            state   <= state_nxt;
            dbginit <= (state_nxt != ST_ASSERT);
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            if (take_start) begin
                pulse_cnt <= '0;
                cnt_val   <= sat_m1_assert(assert_cycles);
            end else if (state == ST_RELEASE) begin
                pulse_cnt <= pulse_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_start) begin
            idle_m1 <= sat_m1_idle(idle_cycles);
            num_lat <= num_pulses;
        end
    end

endmodule

// File: doc/dbginit_gen.md
# dbginit_gen

Stimulus sequencer directly upstream of the dbginit monitor: generates the active-low `dbginit` pulse train and the matching `cnt_val` that the monitor consumes. After a `start` request it waits a programmable idle gap and for the design to be quiescent, then drives `dbginit` low for a programmed number of cycles. It repeats this for a programmed pulse count and reports completion or a quiesce timeout. It is instanced once per testbench and fans out to every dbginit monitor.

## Interface
- `ASSERT_W`, 11, width of assert-length input and `cnt_val`
- `IDLE_W`, 16, width of idle-gap input and counter
- `NPULSE_W`, 8, width of pulse-count input and counter
- `TO_CYCLES`, 1024, quiesce timeout in cycles (used only with the timeout macro)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `idle_cycles`  in  IDLE_W  gap before each pulse, latched at start
- `assert_cycles`  in  ASSERT_W  dbginit low length, latched at start
- `num_pulses`  in  NPULSE_W  pulses per request, latched at start
- `quiesce`  in  1  design busy; dbginit must not fall while high
- `dbginit`  out  1  active-low debug init, registered
- `cnt_val`  out  ASSERT_W  check point for monitors = latched length − 1
- `pulse_cnt`  out  NPULSE_W  pulses completed in current request
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at request completion
- `err_timeout`  out  1  one-cycle pulse on quiesce timeout

## Operation
- States: IDLE, WAIT_IDLE, WAIT_Q, ASSERT, RELEASE, DONE.
- IDLE:
  - `start`=1 latches the three config inputs and clears `pulse_cnt`.
  - If `num_pulses`==0, go to DONE; otherwise go to WAIT_IDLE.
  - `start` outside IDLE is ignored.
- WAIT_IDLE: stays max(`idle_cycles`,1) cycles, then goes to WAIT_Q.
- WAIT_Q: goes to ASSERT in the cycle after `quiesce` is sampled 0.
- ASSERT: `dbginit`=0 for max(`assert_cycles`,1) cycles, then goes to RELEASE.
- RELEASE:
  - One cycle with `dbginit`=1; `pulse_cnt` increments.
  - If the new count equals `num_pulses`, go to DONE; otherwise go to WAIT_IDLE.
- DONE: `done`=1 for one cycle, then IDLE.
- `dbginit` is 0 only in ASSERT, so there are never back-to-back low pulses without at least one high cycle between them.
- `cnt_val` = latched length − 1, saturating at 0; a latched length of 0 is treated as 1, so `cnt_val`=0.
- `cnt_val` is held stable from start until the next start.
- `quiesce` is sampled only in WAIT_Q. Changes of `quiesce` during ASSERT have no effect.
- Reset values: state IDLE, `dbginit`=1, `cnt_val`=0, `pulse_cnt`=0, `busy`=0, `done`=0, `err_timeout`=0.
- `rst` mid-operation: `dbginit` returns to 1 at the same edge; no `done` is generated.

## Timing
- Sampling: `start` is sampled at the end of cycle 0.
- Pulse placement with `idle_cycles`≤1 and `quiesce`=0:
  - WAIT_IDLE in cycle 1 and WAIT_Q in cycle 2.
  - `dbginit` low in cycles 3 .. 3+A−1, where A = max(`assert_cycles`,1).
  - RELEASE in cycle 3+A.
- Period between pulse starts: max(I,1) + 1 + A + 1 cycles when `quiesce`=0, where I = `idle_cycles`.
- `done` asserts the cycle after the final RELEASE; `busy` falls with the return to IDLE.
- `num_pulses`=0: `done` in cycle 1, `dbginit` never falls.

## Configuration
- Macro `DBGINIT_GEN_QTIMEOUT_EN`.
- Defined:
  - A counter runs while in WAIT_Q with `quiesce`=1.
  - After TO_CYCLES consecutive such cycles: `err_timeout` pulses for one cycle, state goes to IDLE, no `done`, `pulse_cnt` is held.
  - The counter clears whenever `quiesce`=0 or on leaving WAIT_Q.
- Undefined: WAIT_Q waits indefinitely and `err_timeout` is tied 0.

## Structure
- Package `dbginit_pkg` holds:
  - the state enum;
  - default widths ASSERT_W, IDLE_W, NPULSE_W;
  - the TO_CYCLES default.
- Sub-module `dbginit_dcnt`: a loadable down-counter with a zero flag.
  - Parameter: width.
  - Instanced for the idle gap, the assert length and the timeout counter.

## Test plan
- `idle`=0, `assert`=5, `num`=1, `quiesce`=0, start at cycle 0:
  - `dbginit` low cycles 3–7, `cnt_val`=4.
  - `done` at cycle 9, `pulse_cnt`=1.
- `idle`=3, `assert`=2, `num`=3: three low pulses of 2 cycles with starts 7 cycles apart; `pulse_cnt` ends at 3; one `done`.
- `quiesce`=1 held for 20 cycles in WAIT_Q, then 0: `dbginit` falls exactly 1 cycle after `quiesce` drops; `err_timeout` stays 0.
- With macro and TO_CYCLES=16, `quiesce` stuck at 1: `err_timeout` pulses once, 16 cycles into WAIT_Q; `dbginit` never falls; `busy`=0 afterwards.
- `rst`=1 on the 3rd ASSERT cycle: `dbginit`=1 and state IDLE at the next edge, no `done`. A second `start` pulsed mid-request is ignored.
- `num`=0 and `assert`=0 edge cases:
  - `num`=0 gives `done` at cycle 1 with no pulse.
  - `assert`=0 gives a 1-cycle low pulse with `cnt_val`=0.
